// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: opcode/funct constants, pc_sel encoding and FSM/class types for pc_sequencer
package pc_seq_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [1:0] PCSEL_INC    = 2'd0;
  localparam logic [1:0] PCSEL_JUMP   = 2'd1;
  localparam logic [1:0] PCSEL_BRANCH = 2'd2;
  localparam logic [1:0] PCSEL_REG    = 2'd3;
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT} state_t;
  typedef enum logic [3:0] {CLS_J, CLS_JAL, CLS_JR, CLS_ALU, CLS_BEQ, CLS_BNE, CLS_LW, CLS_SW, CLS_ILLEGAL} cls_t;
endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: combinational map from instruction word to instruction class
//   instr : 32-bit instruction register contents
//   cls   : instruction class (CLS_ILLEGAL for unsupported opcodes)
module instr_class_decode
  import pc_seq_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [31:0] instr,
  output cls_t        cls
);
  logic [OPW-1:0] op, fn;
  logic unused_bits;
  assign op = instr[31:32-OPW];
  assign fn = instr[OPW-1:0];
  assign unused_bits = ^instr[31-OPW:OPW];
  always_comb
    cls = op == OP_J   ? CLS_J :
          op == OP_JAL ? CLS_JAL :
          op == OP_RTYPE ? (fn == FN_JR ? CLS_JR : CLS_ALU) :
          op == OP_BEQ ? CLS_BEQ :
          op == OP_BNE ? CLS_BNE :
          op == OP_LW  ? CLS_LW :
          op == OP_SW  ? CLS_SW :
          (op == OP_ADDI || op == OP_ORI) ? CLS_ALU : CLS_ILLEGAL;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM owning the PC commit
//   clk, rst_n          : clock, asynchronous active-low reset
//   instr, alu_zero     : instruction register, ALU zero flag (EXEC)
//   imem_ack, dmem_ack  : memory handshake completions
//   imem_req, ir_we     : fetch request, instruction register load
//   pc_we, pc_sel       : one commit pulse per instruction and next-PC select
//   dmem_req, dmem_we   : data memory request / write
//   reg_we, link_sel    : register writeback, PC+4 link select for JAL
//   fault               : sticky illegal-opcode / fetch-timeout flag
//   retired, stall_cycles : performance counters, present only with PC_SEQ_PERF_EN
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int IMEM_TIMEOUT = 0,
  parameter int OPW          = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        link_sel,
`ifdef PC_SEQ_PERF_EN
  output logic [31:0] retired,
  output logic [31:0] stall_cycles,
`endif
  output logic        fault
);
  state_t state;
  cls_t cls_d, cls_q;
  logic [31:0] wait_cnt;
  logic taken, timeout;
  instr_class_decode #(.OPW(OPW)) u_dec (.instr(instr), .cls(cls_d));
  assign taken = cls_q == CLS_BEQ ? alu_zero : !alu_zero;
  // wait_cnt counts FETCH cycles already spent; expiry only when this cycle also lacks an ack
  assign timeout = IMEM_TIMEOUT != 0 && !imem_ack && wait_cnt == 32'(IMEM_TIMEOUT - 1);
  always_comb begin
    imem_req = state == ST_FETCH;
    ir_we    = imem_req && imem_ack;
    dmem_req = state == ST_MEM;
    dmem_we  = dmem_req && cls_q == CLS_SW;
    reg_we   = state == ST_WB;
    link_sel = reg_we && cls_q == CLS_JAL;
    pc_we    = (state == ST_DECODE && (cls_d == CLS_J || cls_d == CLS_JR)) ||
               (state == ST_EXEC && (cls_q == CLS_BEQ || cls_q == CLS_BNE)) ||
               (dmem_we && dmem_ack) || reg_we;
    pc_sel   = !pc_we ? PCSEL_INC :
               state == ST_DECODE ? (cls_d == CLS_JR ? PCSEL_REG : PCSEL_JUMP) :
               state == ST_EXEC ? (taken ? PCSEL_BRANCH : PCSEL_INC) :
               link_sel ? PCSEL_JUMP : PCSEL_INC;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cls_q    <= CLS_ILLEGAL;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= state == ST_FETCH ? wait_cnt + 32'd1 : '0;
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH:
          if (imem_ack) state <= ST_DECODE;
          else if (timeout) begin
            state <= ST_HALT;
            fault <= 1'b1;
          end
        ST_DECODE: begin
          cls_q <= cls_d;
          case (cls_d)
            CLS_J, CLS_JR: state <= ST_FETCH;
            CLS_JAL: state <= ST_WB;
            CLS_ILLEGAL: begin
              state <= ST_HALT;
              fault <= 1'b1;
            end
            default: state <= ST_EXEC;
          endcase
        end
        ST_EXEC:
          state <= (cls_q == CLS_BEQ || cls_q == CLS_BNE) ? ST_FETCH :
                   (cls_q == CLS_LW || cls_q == CLS_SW) ? ST_MEM : ST_WB;
        ST_MEM: if (dmem_ack) state <= cls_q == CLS_SW ? ST_FETCH : ST_WB;
        ST_WB: state <= ST_FETCH;
        default: state <= ST_HALT;
      endcase
    end
  end
`ifdef PC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else begin
      if (pc_we) retired <= retired + 32'd1;
      if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven, random and directed checks of pc_sequencer against a latency/commit model
module tb_pc_sequencer;
  logic clk = 0, rst_n = 1, alu_zero = 0, imem_ack = 0, dmem_ack = 0;
  logic [31:0] instr = 0;
  logic imem_req, ir_we, pc_we, dmem_req, dmem_we, reg_we, link_sel, fault;
  logic [1:0] pc_sel;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] retired, stall_cycles;
`endif
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [31:0] ins;
    logic az;
    int iw, dw, cyc;
    logic [1:0] sel;
    logic rw, lk;
    int dm;
    logic dwe;
  } vec_t;
  typedef struct {
    int cyc, we_n, dm, ir_n, bad;
    logic [1:0] sel;
    logic rw, lk, dwe, halted;
  } obs_t;
  vec_t vecs[14];
  vec_t perf[10];
  always #5 clk = ~clk;
  pc_sequencer #(.IMEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .link_sel(link_sel),
`ifdef PC_SEQ_PERF_EN
    .retired(retired), .stall_cycles(stall_cycles),
`endif
    .fault(fault)
  );
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int outs();
    return int'({imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_we, reg_we, link_sel, fault});
  endfunction
  // Expected behaviour straight from the instruction-class rules: latency, commit select, writeback
  function automatic vec_t model(input logic [31:0] ins, input logic az, input int iw, input int dw);
    vec_t v;
    logic [5:0] op, fn;
    logic jr, alu;
    op = ins[31:26];
    fn = ins[5:0];
    jr = op == 6'h00 && fn == 6'h08;
    alu = (op == 6'h00 && !jr) || op == 6'h08 || op == 6'h0d;
    v.ins = ins; v.az = az; v.iw = iw; v.dw = dw;
    v.cyc = iw + ((op == 6'h02 || jr) ? 2 : (op == 6'h03 || op == 6'h04 || op == 6'h05) ? 3 :
                  op == 6'h23 ? 5 + dw : op == 6'h2b ? 4 + dw : 4);
    v.sel = (op == 6'h02 || op == 6'h03) ? 2'd1 : jr ? 2'd3 :
            op == 6'h04 ? (az ? 2'd2 : 2'd0) : op == 6'h05 ? (az ? 2'd0 : 2'd2) : 2'd0;
    v.rw = alu || op == 6'h03 || op == 6'h23;
    v.lk = op == 6'h03;
    v.dm = (op == 6'h23 || op == 6'h2b) ? dw + 1 : 0;
    v.dwe = op == 6'h2b;
    return v;
  endfunction
  // Acts as instruction/data memory: acks after iw / dw wait cycles; noise on imem_ack outside FETCH
  task automatic run(input logic [31:0] ins, input logic az, input int iw, input int dw, output obs_t o);
    int fc, mc;
    fc = 0; mc = 0;
    o = '{default: 0};
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      instr = ins;
      alu_zero = az;
      imem_ack = imem_req ? (fc >= iw) : 1'($urandom);
      dmem_ack = dmem_req && mc >= dw;
      if (imem_req) fc++;
      if (dmem_req) mc++;
      #1;
      o.cyc++;
      o.ir_n += int'(ir_we);
      o.dm += int'(dmem_req);
      o.dwe |= dmem_we;
      if (pc_sel != 2'd0 && !pc_we) o.bad++;
      if (pc_we) begin
        o.we_n++;
        o.sel = pc_sel;
        o.rw = reg_we;
        o.lk = link_sel;
      end
      if (pc_we || fault) begin
        o.halted = fault;
        return;
      end
    end
    o.cyc = -1;
  endtask
  task automatic check_vec(input string tag, input obs_t o, input vec_t v);
    chk({tag, " cycles"}, o.cyc, v.cyc);
    chk({tag, " pc_sel"}, int'(o.sel), int'(v.sel));
    chk({tag, " reg_we"}, int'(o.rw), int'(v.rw));
    chk({tag, " link_sel"}, int'(o.lk), int'(v.lk));
    chk({tag, " dmem_req cycles"}, o.dm, v.dm);
    chk({tag, " dmem_we"}, int'(o.dwe), int'(v.dwe));
    chk({tag, " pc_we pulses"}, o.we_n, 1);
    chk({tag, " ir_we pulses"}, o.ir_n, 1);
    chk({tag, " pc_sel w/o pc_we"}, o.bad, 0);
    chk({tag, " fault"}, int'(o.halted), 0);
  endtask
  task automatic do_reset();
    rst_n = 0;
    imem_ack = 0;
    dmem_ack = 0;
    #1;
    chk("reset outputs", outs(), 0);
    @(negedge clk);
    #1;
    chk("reset held outputs", outs(), 0);
    rst_n = 1;
    #1;
    chk("idle outputs", outs(), 0);
  endtask
  initial begin
    obs_t o;
    vec_t v;
    logic [31:0] ins;
    logic [5:0] ops[10];
    int k, seen, we_seen, req_seen;
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h08, 6'h0d};
    vecs[0]  = '{32'h012A4020, 1'b0, 0, 0, 4, 2'd0, 1'b1, 1'b0, 0, 1'b0};
    vecs[1]  = '{32'h11090003, 1'b1, 0, 0, 3, 2'd2, 1'b0, 1'b0, 0, 1'b0};
    vecs[2]  = '{32'h11090003, 1'b0, 0, 0, 3, 2'd0, 1'b0, 1'b0, 0, 1'b0};
    vecs[3]  = '{32'h15090003, 1'b1, 0, 0, 3, 2'd0, 1'b0, 1'b0, 0, 1'b0};
    vecs[4]  = '{32'h15090003, 1'b0, 0, 0, 3, 2'd2, 1'b0, 1'b0, 0, 1'b0};
    vecs[5]  = '{32'h8D280004, 1'b0, 0, 3, 8, 2'd0, 1'b1, 1'b0, 4, 1'b0};
    vecs[6]  = '{32'hAD280004, 1'b0, 0, 0, 4, 2'd0, 1'b0, 1'b0, 1, 1'b1};
    vecs[7]  = '{32'h0C000010, 1'b0, 0, 0, 3, 2'd1, 1'b1, 1'b1, 0, 1'b0};
    vecs[8]  = '{32'h03E00008, 1'b0, 0, 0, 2, 2'd3, 1'b0, 1'b0, 0, 1'b0};
    vecs[9]  = '{32'h08000010, 1'b0, 0, 0, 2, 2'd1, 1'b0, 1'b0, 0, 1'b0};
    vecs[10] = '{32'h21080001, 1'b0, 2, 0, 6, 2'd0, 1'b1, 1'b0, 0, 1'b0};
    vecs[11] = '{32'h35080001, 1'b0, 0, 0, 4, 2'd0, 1'b1, 1'b0, 0, 1'b0};
    vecs[12] = '{32'h012A4020, 1'b0, 7, 0, 11, 2'd0, 1'b1, 1'b0, 0, 1'b0};
    vecs[13] = '{32'hAD280004, 1'b0, 0, 2, 6, 2'd0, 1'b0, 1'b0, 3, 1'b1};
    #2;
    do_reset();
    foreach (vecs[i]) begin
      run(vecs[i].ins, vecs[i].az, vecs[i].iw, vecs[i].dw, o);
      check_vec($sformatf("vec%0d", i), o, vecs[i]);
    end
    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      k = $urandom_range(0, 9);
      ins[31:26] = ops[k];
      if (k == 0 && ins[5:0] == 6'h08) ins[5:0] = 6'h20;
      if (k == 1) ins[5:0] = 6'h08;
      v = model(ins, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      run(v.ins, v.az, v.iw, v.dw, o);
      check_vec($sformatf("rand%0d %h", n, ins), o, v);
    end
    run(32'h012A4020, 1'b0, 50, 0, o);
    chk("timeout cycles", o.cyc, 9);
    chk("timeout fault", int'(o.halted), 1);
    chk("timeout pc_we", o.we_n, 0);
    do_reset();
    run(32'hFC000000, 1'b0, 0, 0, o);
    chk("illegal cycles", o.cyc, 3);
    chk("illegal fault", int'(o.halted), 1);
    chk("illegal pc_we", o.we_n, 0);
    req_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      imem_ack = 1;
      dmem_ack = 1;
      #1;
      if (outs() != 1) req_seen++;
    end
    chk("halt absorbing", req_seen, 0);
    do_reset();
    seen = 0;
    we_seen = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(negedge clk);
      instr = 32'h8D280004;
      imem_ack = imem_req;
      dmem_ack = 0;
      #1;
      if (dmem_req) seen++;
      if (pc_we) we_seen++;
    end
    chk("reached mem", seen, 2);
    #2;
    rst_n = 0;
    #1;
    chk("mid-mem reset outputs", outs(), 0);
    chk("mid-mem no commit", we_seen, 0);
    @(negedge clk);
    rst_n = 1;
`ifdef PC_SEQ_PERF_EN
    perf[0] = model(32'h012A4020, 1'b0, 1, 0);
    perf[1] = model(32'h11090003, 1'b1, 0, 0);
    perf[2] = model(32'h8D280004, 1'b0, 0, 2);
    perf[3] = model(32'hAD280004, 1'b0, 0, 0);
    perf[4] = model(32'h08000010, 1'b0, 1, 0);
    perf[5] = model(32'h0C000010, 1'b0, 0, 0);
    perf[6] = model(32'h03E00008, 1'b0, 0, 0);
    perf[7] = model(32'h35080001, 1'b0, 0, 0);
    perf[8] = model(32'h21080001, 1'b0, 1, 0);
    perf[9] = model(32'h15090003, 1'b0, 0, 0);
    do_reset();
    chk("retired reset", int'(retired), 0);
    chk("stall reset", int'(stall_cycles), 0);
    foreach (perf[i]) begin
      run(perf[i].ins, perf[i].az, perf[i].iw, perf[i].dw, o);
      check_vec($sformatf("perf%0d", i), o, perf[i]);
    end
    @(negedge clk);
    #1;
    chk("retired", int'(retired), 10);
    chk("stall_cycles", int'(stall_cycles), 5);
`else
    perf[0] = vecs[0];
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
